// File: rtl/ttl_74161.sv
// 74161-style synchronous presettable binary counter with asynchronous active-low clear.
// Define TTL_74161_MODULUS_EN to make the count wrap at MODULUS instead of 2^WIDTH.
module ttl_74161 #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 10,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Load_bar,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_next;
    logic             rco_d;

    if (MODULUS < 2) begin : g_bad_modulus_low
        $error("ttl_74161: MODULUS must be at least 2");
    end

`ifdef TTL_74161_MODULUS_EN
    if (MODULUS > (1 << WIDTH)) begin : g_bad_modulus_high
        $error("ttl_74161: MODULUS exceeds 2^WIDTH");
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    // A loaded value above the terminal count also wraps to 0 on the next count.
    assign q_next = (q_q >= TERM) ? '0 : q_q + WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] TERM = '1;

    assign q_next = q_q + WIDTH'(1);
`endif

    always_comb begin
        q_d = q_q;
        if (!Load_bar) begin
            q_d = D;
        end else if (ENP && ENT) begin
            q_d = q_next;
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign rco_d = ENT && (q_q == TERM);

    // Output delay is a simulation model of the part; synthesis ignores it.
    if (DELAY_RISE == DELAY_FALL) begin : g_out_sym
        assign #(DELAY_RISE) {Q, RCO} = {q_q, rco_d};
    end else begin : g_out_asym
        assign #(DELAY_RISE, DELAY_FALL) {Q, RCO} = {q_q, rco_d};
    end

endmodule
